// File: rtl/inst_pkg.sv
// Shared RV32I encoding constants, format/error enums and the immediate range
// classifier used by the instruction encoder.
package inst_pkg;

    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [31:0] NOP_INST  = 32'h0000_0013;

    typedef enum logic [1:0] {
        ERR_OK    = 2'b00,
        ERR_RANGE = 2'b01,
        ERR_ALIGN = 2'b10,
        ERR_BAD   = 2'b11
    } err_t;

    typedef enum logic [2:0] {
        FMT_I   = 3'd0,
        FMT_S   = 3'd1,
        FMT_B   = 3'd2,
        FMT_U   = 3'd3,
        FMT_J   = 3'd4,
        FMT_BAD = 3'd5
    } fmt_t;

    function automatic fmt_t classify(input logic [6:0] op);
        fmt_t f;
        case (op)
            OP_IMM:    f = FMT_I;
            OP_STORE:  f = FMT_S;
            OP_BRANCH: f = FMT_B;
            OP_LUI:    f = FMT_U;
            OP_JAL:    f = FMT_J;
            default:   f = FMT_BAD;
        endcase
        return f;
    endfunction

    // Priority is BAD_OPCODE, then ALIGN (B/J only), then RANGE.
    function automatic err_t imm_check(input fmt_t fmt, input logic [31:0] imm);
        logic signed [31:0] s;
        err_t e;
        s = $signed(imm);
        e = ERR_OK;
        case (fmt)
            FMT_I, FMT_S: begin
                if (s < -2048 || s > 2047) e = ERR_RANGE;
            end
            FMT_B: begin
                if (imm[0]) e = ERR_ALIGN;
                else if (s < -4096 || s > 4094) e = ERR_RANGE;
            end
            FMT_J: begin
                if (imm[0]) e = ERR_ALIGN;
                else if (s < -1048576 || s > 1048574) e = ERR_RANGE;
            end
            FMT_U: begin
                if (imm[11:0] != 12'd0) e = ERR_RANGE;
            end
            default: e = ERR_BAD;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational packer: scatters register fields and immediate bits into the
// RV32I word layout of the selected format; unknown formats become a NOP.
module inst_pack
    import inst_pkg::*;
(
    input  logic [2:0]  i_fmt,
    input  logic [6:0]  i_op,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_f3,
    input  logic [31:0] i_imm,
    output logic [31:0] o_inst
);

    fmt_t w_fmt;
    assign w_fmt = fmt_t'(i_fmt);

    // Out-of-range immediates are simply truncated to the bits the format holds.
    always_comb begin
        o_inst = NOP_INST;
        case (w_fmt)
            FMT_I:   o_inst = {i_imm[11:0], i_rs1, i_f3, i_rd, i_op};
            FMT_S:   o_inst = {i_imm[11:5], i_rs2, i_rs1, i_f3, i_imm[4:0], i_op};
            FMT_B:   o_inst = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_f3,
                               i_imm[4:1], i_imm[11], i_op};
            FMT_U:   o_inst = {i_imm[31:12], i_rd, i_op};
            FMT_J:   o_inst = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12],
                               i_rd, i_op};
            default: o_inst = NOP_INST;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage RV32I instruction encoder: S1 registers fields and classifies the
// immediate, S2 packs and presents the word. Valid/ready on both sides.
module inst_encoder
    import inst_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       op_code,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      inst,
    output logic [1:0]       err,
    output logic [CNT_W-1:0] n_enc,
    output logic [CNT_W-1:0] n_err
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             r_s1_v;
    logic [6:0]       r_s1_op;
    logic [4:0]       r_s1_rd;
    logic [4:0]       r_s1_rs1;
    logic [4:0]       r_s1_rs2;
    logic [2:0]       r_s1_f3;
    logic [31:0]      r_s1_imm;
    fmt_t             r_s1_fmt;
    err_t             r_s1_err;

    logic             r_s2_v;
    logic [31:0]      r_inst;
    err_t             r_err;
    logic [CNT_W-1:0] r_n_enc;
    logic [CNT_W-1:0] r_n_err;

    fmt_t             w_fmt;
    err_t             w_err;
    logic             w_s2_adv;
    logic             w_in_ready;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [31:0]      w_packed;

    assign w_fmt      = classify(op_code);
    assign w_err      = imm_check(w_fmt, imm);

    // S2 can take a new entry when it is empty or is being drained this cycle.
    assign w_s2_adv   = !r_s2_v || out_ready;
    assign w_in_ready = !RESET && (!r_s1_v || w_s2_adv);
    assign w_in_xfer  = in_valid && w_in_ready;
    assign w_out_xfer = r_s2_v && out_ready;

    inst_pack u_pack (
        .i_fmt  (r_s1_fmt),
        .i_op   (r_s1_op),
        .i_rd   (r_s1_rd),
        .i_rs1  (r_s1_rs1),
        .i_rs2  (r_s1_rs2),
        .i_f3   (r_s1_f3),
        .i_imm  (r_s1_imm),
        .o_inst (w_packed)
    );

    always_ff @(posedge CLK) begin
        if (w_in_xfer) begin
            r_s1_op  <= op_code;
            r_s1_rd  <= rd;
            r_s1_rs1 <= rs1;
            r_s1_rs2 <= rs2;
            r_s1_f3  <= funct3;
            r_s1_imm <= imm;
            r_s1_fmt <= w_fmt;
            r_s1_err <= w_err;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_s1_v  <= 1'b0;
            r_s2_v  <= 1'b0;
            r_inst  <= 32'd0;
            r_err   <= ERR_OK;
            r_n_enc <= '0;
            r_n_err <= '0;
        end else begin
            if (w_in_xfer)     r_s1_v <= 1'b1;
            else if (w_s2_adv) r_s1_v <= 1'b0;

            if (w_s2_adv) begin
                r_s2_v <= r_s1_v;
                if (r_s1_v) begin
                    r_inst <= w_packed;
                    r_err  <= r_s1_err;
                end
            end

            if (w_out_xfer) begin
                if (r_n_enc != CNT_MAX) r_n_enc <= r_n_enc + CNT_ONE;
                if (r_err != ERR_OK && r_n_err != CNT_MAX) r_n_err <= r_n_err + CNT_ONE;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_s2_v;
    assign inst      = r_inst;
    assign err       = r_err;
    assign n_enc     = r_n_enc;
    assign n_err     = r_n_err;

endmodule
